// File: rtl/prog_loader_if.sv
// Host/RAM-side bundle for prog_loader: byte stream handshake plus the MAR/RAM program path.
// The chksum signal exists only when PROG_LOADER_CHKSUM_EN is defined.
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              we;
    logic              select;
    logic              busy;
    logic              done;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [DATA_W-1:0] chksum;

    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, prog_addr, prog_data, we, select, busy, done, chksum
    );
    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, prog_addr, prog_data, we, select, busy, done, chksum
    );
`else
    modport master (
        output start, in_valid, in_data, in_last,
        input  in_ready, prog_addr, prog_data, we, select, busy, done
    );
    modport slave (
        input  start, in_valid, in_data, in_last,
        output in_ready, prog_addr, prog_data, we, select, busy, done
    );
`endif
endinterface

// File: rtl/prog_loader.sv
// SAP-1 program-mode loader: writes a valid/ready byte stream into RAM from address 0 upward.
// Optional running byte checksum output enabled by defining PROG_LOADER_CHKSUM_EN.
module prog_loader #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WR_CYCLES = 1
) (
    input logic          clk,
    input logic          clr_n,
    prog_loader_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StRun} state_e;

    localparam int unsigned CntW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WR_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              sel_q, sel_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_q, last_d;
`ifdef PROG_LOADER_CHKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
`ifdef PROG_LOADER_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        last_d  = last_q;
`ifdef PROG_LOADER_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            StIdle, StRun: begin
                if (bus.start) begin
                    state_d = StLoad;
                    addr_d  = '0;
                    sel_d   = 1'b0;
                    ready_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (bus.in_valid && ready_q) begin
                    state_d = StWrite;
                    data_d  = bus.in_data;
                    last_d  = bus.in_last;
                    ready_d = 1'b0;
                    we_d    = 1'b1;
                    cnt_d   = '0;
`ifdef PROG_LOADER_CHKSUM_EN
                    chk_d   = chk_q + bus.in_data;
`endif
                end
            end
            StWrite: begin
                if (cnt_q == CntLast) begin
                    we_d = 1'b0;
                    // Top address ends the image even without in_last: no wrap onto address 0.
                    if (last_q || (&addr_q)) begin
                        state_d = StRun;
                        sel_d   = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = StLoad;
                        addr_d  = addr_q + ADDR_W'(1);
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready  = ready_q;
    assign bus.prog_addr = addr_q;
    assign bus.prog_data = data_q;
    assign bus.we        = we_q;
    assign bus.select    = sel_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
`ifdef PROG_LOADER_CHKSUM_EN
    assign bus.chksum    = chk_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (one- and three-clock write pulses) share a clock.
// The checksum checks are compiled only when PROG_LOADER_CHKSUM_EN is defined.
module tb_prog_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    prog_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    prog_loader #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(1)) dut0 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus0)
    );
    prog_loader #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(3)) dut1 (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus1)
    );

    logic          start_s [2];
    logic          valid_s [2];
    logic          last_s  [2];
    logic [DW-1:0] data_s  [2];

    assign bus0.start    = start_s[0];
    assign bus0.in_valid = valid_s[0];
    assign bus0.in_last  = last_s[0];
    assign bus0.in_data  = data_s[0];
    assign bus1.start    = start_s[1];
    assign bus1.in_valid = valid_s[1];
    assign bus1.in_last  = last_s[1];
    assign bus1.in_data  = data_s[1];

    logic          ready_w [2];
    logic          we_w    [2];
    logic          sel_w   [2];
    logic          busy_w  [2];
    logic          done_w  [2];
    logic [AW-1:0] addr_w  [2];
    logic [DW-1:0] pdata_w [2];

    assign ready_w[0] = bus0.in_ready;
    assign we_w[0]    = bus0.we;
    assign sel_w[0]   = bus0.select;
    assign busy_w[0]  = bus0.busy;
    assign done_w[0]  = bus0.done;
    assign addr_w[0]  = bus0.prog_addr;
    assign pdata_w[0] = bus0.prog_data;
    assign ready_w[1] = bus1.in_ready;
    assign we_w[1]    = bus1.we;
    assign sel_w[1]   = bus1.select;
    assign busy_w[1]  = bus1.busy;
    assign done_w[1]  = bus1.done;
    assign addr_w[1]  = bus1.prog_addr;
    assign pdata_w[1] = bus1.prog_data;

    typedef struct packed {
        logic          id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic          id;
        logic [AW-1:0] addr;
    } dn_t;

    wr_t           exp_wr[$];
    dn_t           exp_dn[$];
    logic [DW-1:0] tx[$];
    int            n_chk  = 0;
    int            n_pass = 0;

    function automatic int wr_len(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expected write on every WE rise and an expected end state on every DONE.
    initial begin
        logic          we_p [2];
        logic          dn_p [2];
        int            len  [2];
        logic          stab [2];
        logic [AW-1:0] ha   [2];
        logic [DW-1:0] hd   [2];
        wr_t           e;
        dn_t           f;
        for (int i = 0; i < 2; i++) begin
            we_p[i] = 1'b0;
            dn_p[i] = 1'b0;
            len[i]  = 0;
            stab[i] = 1'b1;
            ha[i]   = '0;
            hd[i]   = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!clr_n) begin
                    we_p[i] = 1'b0;
                    dn_p[i] = 1'b0;
                end else begin
                    if (we_w[i] && !we_p[i]) begin
                        if (exp_wr.size() == 0) begin
                            n_chk++;
                            $display("FAIL spurious_write: dut%0d addr 0x%0h data 0x%0h, none expected",
                                     i, addr_w[i], pdata_w[i]);
                        end else begin
                            e = exp_wr.pop_front();
                            check("wr_dut", i, e.id);
                            check("wr_addr", addr_w[i], e.addr);
                            check("wr_data", pdata_w[i], e.data);
                        end
                        ha[i]   = addr_w[i];
                        hd[i]   = pdata_w[i];
                        len[i]  = 1;
                        stab[i] = 1'b1;
                    end else if (we_w[i]) begin
                        len[i]++;
                        if (addr_w[i] != ha[i] || pdata_w[i] != hd[i]) stab[i] = 1'b0;
                    end else if (we_p[i]) begin
                        check("we_width", len[i], wr_len(i));
                        check("wr_stable", stab[i], 1);
                    end
                    if (done_w[i]) begin
                        check("done_single", dn_p[i], 0);
                        if (exp_dn.size() == 0) begin
                            n_chk++;
                            $display("FAIL spurious_done: dut%0d addr 0x%0h, none expected", i, addr_w[i]);
                        end else begin
                            f = exp_dn.pop_front();
                            check("done_dut", i, f.id);
                            check("done_addr", addr_w[i], f.addr);
                            check("done_select", sel_w[i], 1);
                            check("done_busy", busy_w[i], 0);
                        end
                    end
                    we_p[i] = we_w[i];
                    dn_p[i] = done_w[i];
                end
            end
        end
    end

    // Streams tx[first..] into dut d; abort>0 returns right after that many handshakes.
    task automatic load(input int d, input int first, input bit do_start, input bit use_last,
                        input bit toggle, input int abort, input int fin, input int exp_cyc);
        int idx = first;
        int cyc = 0;
        int acc = 0;
        bit ph  = 1'b0;
        if (abort == 0) exp_dn.push_back('{id: d[0], addr: AW'(fin)});
        if (do_start) begin
            start_s[d] = 1'b1;
            step();
            start_s[d] = 1'b0;
        end
        while (idx < tx.size() && cyc < 400) begin
            valid_s[d] = toggle ? ph : 1'b1;
            data_s[d]  = tx[idx];
            last_s[d]  = use_last && (idx == tx.size() - 1);
            if (valid_s[d] && ready_w[d]) begin
                exp_wr.push_back('{id: d[0], addr: AW'(idx), data: tx[idx]});
                idx++;
                acc++;
            end
            step();
            cyc++;
            ph = ~ph;
            if (abort != 0 && acc == abort) begin
                valid_s[d] = 1'b0;
                last_s[d]  = 1'b0;
                return;
            end
        end
        valid_s[d] = 1'b0;
        last_s[d]  = 1'b0;
        while (!sel_w[d] && cyc < 400) begin
            step();
            cyc++;
        end
        check("load_complete", sel_w[d], 1);
        if (exp_cyc > 0) check("load_cycles", cyc, exp_cyc);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            valid_s[i] = 1'b0;
            last_s[i]  = 1'b0;
            data_s[i]  = '0;
        end
        clr_n = 1'b0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            check("rst_select", sel_w[i], 0);
            check("rst_addr", addr_w[i], 0);
            check("rst_data", pdata_w[i], 0);
            check("rst_we", we_w[i], 0);
            check("rst_ready", ready_w[i], 0);
            check("rst_busy", busy_w[i], 0);
            check("rst_done", done_w[i], 0);
        end
        #3 clr_n = 1'b1;
        step();
        check("idle_ready", ready_w[0], 0);
        check("idle_busy", busy_w[0], 0);

        // Three-byte image with IN_LAST, two clocks per byte
        tx = '{8'h11, 8'h22, 8'h33};
        load(0, 0, 1'b1, 1'b1, 1'b0, 0, 2, 6);
        check("run_addr", addr_w[0], 2);
        check("run_select", sel_w[0], 1);
        check("run_ready", ready_w[0], 0);
        check("run_done_low", done_w[0], 0);

        // Full image, no IN_LAST: stops at top address
        tx = {};
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        load(0, 0, 1'b1, 1'b0, 1'b0, 0, 15, 32);
        valid_s[0] = 1'b1;
        data_s[0]  = 8'hEE;
        repeat (4) step();
        valid_s[0] = 1'b0;
        check("full_addr", addr_w[0], 15);
        check("full_ready", ready_w[0], 0);
        check("full_select", sel_w[0], 1);

        // IN_VALID toggled every other cycle
        tx = '{8'h5A, 8'hC3, 8'h7E, 8'h81};
        load(0, 0, 1'b1, 1'b1, 1'b1, 0, 3, -1);
        check("toggle_addr", addr_w[0], 3);

        // Three-clock write pulse; START during LOAD ignored
        tx = '{8'hD0, 8'hD1, 8'hD2};
        load(1, 0, 1'b1, 1'b1, 1'b0, 1, 0, -1);
        w = 0;
        while (!ready_w[1] && w < 20) begin
            step();
            w++;
        end
        check("wr3_reload_ready", ready_w[1], 1);
        check("wr3_reload_addr", addr_w[1], 1);
        start_s[1] = 1'b1;
        step();
        start_s[1] = 1'b0;
        check("start_in_load_addr", addr_w[1], 1);
        check("start_in_load_ready", ready_w[1], 1);
        check("start_in_load_busy", busy_w[1], 1);
        load(1, 1, 1'b0, 1'b1, 1'b0, 0, 2, -1);

        // START in RUN restarts at address 0
        start_s[1] = 1'b1;
        step();
        start_s[1] = 1'b0;
        check("restart_select", sel_w[1], 0);
        check("restart_addr", addr_w[1], 0);
        check("restart_ready", ready_w[1], 1);
        check("restart_busy", busy_w[1], 1);
        tx = '{8'hE0, 8'hE1};
        load(1, 0, 1'b0, 1'b1, 1'b0, 0, 1, 8);

        // Asynchronous reset in the middle of a write pulse
        tx = '{8'hB0, 8'hB1, 8'hB2};
        load(1, 0, 1'b1, 1'b0, 1'b0, 2, 0, -1);
        @(negedge clk);
        #1 clr_n = 1'b0;
        #1;
        check("async_we", we_w[1], 0);
        check("async_select", sel_w[1], 0);
        check("async_addr", addr_w[1], 0);
        check("async_ready", ready_w[1], 0);
        check("async_busy", busy_w[1], 0);
        @(negedge clk);
        clr_n = 1'b1;
        step();

`ifdef PROG_LOADER_CHKSUM_EN
        tx = '{8'hF0, 8'h20};
        load(0, 0, 1'b1, 1'b1, 1'b0, 0, 1, 4);
        check("chksum_sum", bus0.chksum, 8'h10);
        start_s[0] = 1'b1;
        step();
        start_s[0] = 1'b0;
        check("chksum_clear", bus0.chksum, 8'h00);
`endif

        repeat (4) step();
        check("writes_drained", exp_wr.size(), 0);
        check("dones_drained", exp_dn.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
